// File: rtl/mode_counter_pkg.sv
// rtl/mode_counter_pkg.sv - shared mode encodings for the mode counter
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage

// File: rtl/mode_counter_next.sv
// rtl/mode_counter_next.sv - combinational next-count, next-dir and wrap logic
module mode_counter_next
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODN  = 10
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             next_wrap
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODN - 1);
    localparam logic [WIDTH-1:0] LAST_M1 = WIDTH'(MODN - 2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    mode_t m;
    assign m = mode_t'(mode);

    always_comb begin
        next_count = count;
        next_dir   = dir;
        next_wrap  = 1'b0;
        case (m)
            MODE_UP: begin
                next_dir = 1'b1;
                if (count >= LAST) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = count + ONE;
                end
            end
            MODE_DOWN: begin
                next_dir = 1'b0;
                if (count == '0) begin
                    next_count = LAST;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = count - ONE;
                end
            end
            MODE_BOUNCE: begin
                // An endpoint reached with dir still pointing outward turns back in one step.
                if (dir) begin
                    if (count >= LAST) begin
                        next_count = LAST_M1;
                        next_dir   = 1'b0;
                        next_wrap  = 1'b1;
                    end else begin
                        next_count = count + ONE;
                        if (count == LAST_M1) begin
                            next_dir  = 1'b0;
                            next_wrap = 1'b1;
                        end
                    end
                end else begin
                    if (count == '0) begin
                        next_count = ONE;
                        next_dir   = 1'b1;
                        next_wrap  = 1'b1;
                    end else begin
                        next_count = count - ONE;
                        if (count == ONE) begin
                            next_dir  = 1'b1;
                            next_wrap = 1'b1;
                        end
                    end
                end
            end
            default: begin
                next_count = count;
                next_dir   = dir;
                next_wrap  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - modulo up/down/bounce counter with clear, load and wrap pulse
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODN  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             wrap
);

    generate
        if (MODN < 2 || MODN > (1 << WIDTH)) begin : g_bad_modn
            $error("mode_counter: MODN must satisfy 2 <= MODN <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODN - 1);

    logic [WIDTH-1:0] step_count;
    logic             step_dir;
    logic             step_wrap;
    logic [WIDTH-1:0] load_sat;

    // Out-of-range load values saturate so count never leaves 0..MODN-1.
    assign load_sat = (32'(load_val) < 32'(MODN)) ? load_val : LAST;

    mode_counter_next #(
        .WIDTH (WIDTH),
        .MODN  (MODN)
    ) u_next (
        .count      (count),
        .dir        (dir),
        .mode       (mode),
        .next_count (step_count),
        .next_dir   (step_dir),
        .next_wrap  (step_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            dir   <= 1'b1;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            dir   <= 1'b1;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_sat;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= step_count;
            dir   <= step_dir;
            wrap  <= step_wrap;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed self-checking bench for mode_counter (WIDTH=4, MODN=10)
module tb_mode_counter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic [1:0] mode;
    logic [3:0] count;
    logic       dir;
    logic       wrap;

    int vectors     = 0;
    int miscompares = 0;

    mode_counter #(.WIDTH(4), .MODN(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .mode     (mode),
        .count    (count),
        .dir      (dir),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; mode = 2'b00;
        #12;
        vectors++;
        if (count !== 4'd0 || dir !== 1'b1 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got count=%0d dir=%0b wrap=%0b expected 0 1 0", count, dir, wrap);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_up();
        int exp_c;
        logic exp_w;
        mode = 2'b00; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_c = (i + 1) % 10;
            exp_w = (i == 9);
            vectors++;
            if (count !== 4'(exp_c) || wrap !== exp_w || dir !== 1'b1) begin
                miscompares++;
                $display("FAIL up[%0d]: got count=%0d wrap=%0b dir=%0b expected %0d %0b 1", i, count, wrap, dir, exp_c, exp_w);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down();
        int exp_c;
        logic exp_w;
        do_clear();
        mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_c = 9 - (i % 10);
            exp_w = (exp_c == 9);
            vectors++;
            if (count !== 4'(exp_c) || wrap !== exp_w || dir !== 1'b0) begin
                miscompares++;
                $display("FAIL down[%0d]: got count=%0d wrap=%0b dir=%0b expected %0d %0b 0", i, count, wrap, dir, exp_c, exp_w);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_bounce();
        int bexp[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        int dexp[20] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        logic exp_w;
        do_clear();
        mode = 2'b10; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_w = (i == 8) || (i == 17);
            vectors++;
            if (count !== 4'(bexp[i]) || dir !== 1'(dexp[i]) || wrap !== exp_w) begin
                miscompares++;
                $display("FAIL bounce[%0d]: got count=%0d dir=%0b wrap=%0b expected %0d %0d %0b", i, count, dir, wrap, bexp[i], dexp[i], exp_w);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clr_en();
        do_clear();
        mode = 2'b00;
        do_load(4'd12);
        vectors++;
        if (count !== 4'd9 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL load_sat: got count=%0d wrap=%0b expected 9 0", count, wrap);
        end
        // load beats an enabled step from the wrap point: no wrap pulse
        load = 1'b1; load_val = 4'd9; en = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        vectors++;
        if (count !== 4'd9 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL load_over_en: got count=%0d wrap=%0b expected 9 0", count, wrap);
        end
        clr = 1'b1; load = 1'b1; load_val = 4'd6;
        tick();
        clr = 1'b0; load = 1'b0;
        vectors++;
        if (count !== 4'd0 || dir !== 1'b1 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_over_load: got count=%0d dir=%0b wrap=%0b expected 0 1 0", count, dir, wrap);
        end
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (count !== 4'd2 || wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL en_low[%0d]: got count=%0d wrap=%0b expected 2 0", i, count, wrap);
            end
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        vectors++;
        if (count !== 4'd3) begin
            miscompares++;
            $display("FAIL en_resume: got count=%0d expected 3", count);
        end
    endtask

    task automatic test_async_reset();
        do_load(4'd6);
        mode = 2'b01; en = 1'b1;
        tick();
        en = 1'b0;
        vectors++;
        if (count !== 4'd5 || dir !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_rst: got count=%0d dir=%0b expected 5 0", count, dir);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0 || dir !== 1'b1 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: got count=%0d dir=%0b wrap=%0b expected 0 1 0", count, dir, wrap);
        end
        @(negedge clk);
        rst = 1'b0; mode = 2'b00; en = 1'b1;
        tick();
        en = 1'b0;
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("FAIL first_step: got count=%0d expected 1", count);
        end
    endtask

    task automatic test_bounce_endpoint();
        do_clear();
        mode = 2'b10;
        do_load(4'd9);
        en = 1'b1;
        tick();
        vectors++;
        if (count !== 4'd8 || dir !== 1'b0 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_top_turn: got count=%0d dir=%0b wrap=%0b expected 8 0 1", count, dir, wrap);
        end
        tick();
        vectors++;
        if (count !== 4'd7 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_after_turn: got count=%0d wrap=%0b expected 7 0", count, wrap);
        end
        mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (count !== 4'd7 || dir !== 1'b0 || wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: got count=%0d dir=%0b wrap=%0b expected 7 0 0", i, count, dir, wrap);
            end
        end
        mode = 2'b00;
        tick();
        vectors++;
        if (count !== 4'd8 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_change: got count=%0d dir=%0b expected 8 1", count, dir);
        end
        mode = 2'b01;
        tick();
        en = 1'b0;
        mode = 2'b10;
        do_load(4'd0);
        en = 1'b1;
        tick();
        en = 1'b0;
        vectors++;
        if (count !== 4'd1 || dir !== 1'b1 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_bottom_turn: got count=%0d dir=%0b wrap=%0b expected 1 1 1", count, dir, wrap);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_load_clr_en();
        test_async_reset();
        test_bounce_endpoint();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning bit width of count and load_val.
REQ-002 The block SHALL have parameter MODN, default 10, meaning modulus (count range 0..MODN-1), legal 2 <= MODN <= 2**WIDTH.
REQ-003 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port clr  input  1  synchronous clear.
REQ-006 The block SHALL have port load  input  1  synchronous load strobe.
REQ-007 The block SHALL have port load_val  input  WIDTH  value loaded on load.
REQ-008 The block SHALL have port en  input  1  count enable (one step per enabled clock).
REQ-009 The block SHALL have port mode  input  2  00 UP, 01 DOWN, 10 BOUNCE, 11 HOLD.
REQ-010 The block SHALL have port count  output  WIDTH  current count, registered.
REQ-011 The block SHALL have port dir  output  1  current direction, 1 = up, registered.
REQ-012 The block SHALL have port wrap  output  1  one-cycle registered pulse on wrap (UP/DOWN) or turnaround (BOUNCE).

Function
REQ-013 The block SHALL apply priority clr > load > en step; absent all three, count and dir hold and wrap is 0.
REQ-014 On clr the block SHALL set count=0, dir=1, wrap=0 at the next edge, regardless of mode.
REQ-015 On load the block SHALL set count=load_val if load_val<MODN, else MODN-1 (saturate); dir unchanged; wrap=0.
REQ-016 In UP with en, the block SHALL step count+1, and from MODN-1 to 0 with wrap=1 in the cycle count shows 0; dir SHALL be 1.
REQ-017 In DOWN with en, the block SHALL step count-1, and from 0 to MODN-1 with wrap=1 in the cycle count shows MODN-1; dir SHALL be 0.
REQ-018 In BOUNCE with en, the block SHALL step in the direction of dir; on reaching MODN-1 (up) or 0 (down) it SHALL flip dir in the same edge and pulse wrap in the cycle count shows that endpoint.
REQ-019 BOUNCE sequence for MODN=4 from 0, dir=1 SHALL be 0 1 2 3 2 1 0 1 ..., with no endpoint value repeated.
REQ-020 In BOUNCE, a count at an endpoint with dir pointing outward (e.g. after load or mode change) SHALL turn back without leaving range: at MODN-1 with dir=1, next = MODN-2, dir=0, wrap=1.
REQ-021 In HOLD, or with en=0, the block SHALL keep count and dir unchanged and drive wrap=0.
REQ-022 On mode change, the block SHALL keep count unchanged; the new mode takes effect from the same edge the new value is sampled.
REQ-023 count SHALL never leave 0..MODN-1 in any mode or input sequence.
REQ-024 wrap SHALL be high for exactly one cycle per wrap/turnaround event and SHALL not be generated by clr or load.

Reset
REQ-025 On rst high, the block SHALL immediately, independent of clk, set count=0, dir=1, wrap=0.
REQ-026 On rst deassertion, the block SHALL take its first step at the first rising edge with rst low; rst mid-count SHALL discard count and dir.

Structure
REQ-027 A shared package mode_counter_pkg SHALL hold the mode encodings MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_HOLD.
REQ-028 Next-count/next-dir/wrap logic SHALL be a combinational sub-module mode_counter_next; mode_counter holds only registers and priority.
REQ-029 The block SHALL reject illegal MODN (<2 or >2**WIDTH) at elaboration.

Verification (WIDTH=4, MODN=10)
REQ-030 UP, en=1, 12 clocks from reset -> count 1..9,0,1,2; wrap high only in the cycle count shows 0.
REQ-031 DOWN, en=1 from 0 -> count 9,8,...; wrap high with first 9; dir=0.
REQ-032 BOUNCE, en=1, 20 clocks from 0 -> 1..9,8..0,1; wrap high when count shows 9 and when 0.
REQ-033 load with load_val=12 -> count=9; load and clr in the same cycle -> count=0; en toggled low mid-sequence -> count frozen, wrap=0.
REQ-034 rst pulsed between clock edges at count=5 -> count=0, dir=1 immediately, before next edge.
REQ-035 BOUNCE, load 9 while dir=1, then en -> 8, dir=0, wrap=1; switch to HOLD -> count holds for all cycles.
